// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
//==============================================================================
// Module   : muldiv_sequencer_if
// Brief    : Request/result bundle between the execute stage and the
//            multiply/divide sequencer.
// Revision : 1.0 - initial release
//==============================================================================
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] Read_data_1;
    logic [WIDTH-1:0] Read_data_2;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, Read_data_1, Read_data_2, mthi, mtlo,
        input  HI, LO, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, Read_data_1, Read_data_2, mthi, mtlo,
        output HI, LO, busy, done, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : muldiv_sequencer
// Brief    : Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
//            Define MULDIV_FAST_MULT_EN for a single-cycle multiply.
// Revision : 1.0 - initial release
//==============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  wire logic         clock,
    input  wire logic         reset,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_CNT = 6'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [5:0]         r_cnt;
    logic               r_is_div;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_raw_rs;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_signed;
    logic [WIDTH-1:0]   w_rs_abs;
    logic [WIDTH-1:0]   w_rt_abs;
    logic [WIDTH:0]     w_div_rem;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Magnitudes are taken as unsigned, so 0x80000000 keeps its bit pattern.
    assign w_signed = ~bus.op[0];
    assign w_rs_abs = (w_signed && bus.Read_data_1[WIDTH-1]) ? -bus.Read_data_1 : bus.Read_data_1;
    assign w_rt_abs = (w_signed && bus.Read_data_2[WIDTH-1]) ? -bus.Read_data_2 : bus.Read_data_2;

    // Restoring step: shift {rem, quo} left, trial-subtract the divisor, keep on no borrow.
    assign w_div_rem  = r_prod[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_div_rem - {1'b0, r_opb};
    assign w_div_next = w_div_diff[WIDTH]
                      ? {w_div_rem[WIDTH-1:0],  r_prod[WIDTH-2:0], 1'b0}
                      : {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MULT_EN
    localparam logic c_FAST_MULT = 1'b1;
    assign w_mul_next = {{WIDTH{1'b0}}, r_opb} * {{WIDTH{1'b0}}, r_prod[WIDTH-1:0]};
`else
    localparam logic c_FAST_MULT = 1'b0;
    logic [WIDTH:0] w_mul_sum;
    // Shift-add: {acc, multiplier} moves right once per step, adding the multiplicand on a 1.
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    assign w_mul_next = r_prod[0] ? {w_mul_sum, r_prod[WIDTH-1:1]}
                                  : {1'b0, r_prod[2*WIDTH-1:1]};
`endif

    assign w_quo = r_prod[WIDTH-1:0];
    assign w_rem = r_prod[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_CALC;
            S_CALC: if ((r_cnt == c_LAST_CNT) || (c_FAST_MULT && !r_is_div)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_opb    <= '0;
            r_raw_rs <= '0;
            r_prod   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.mthi) r_hi <= bus.Read_data_1;
                    if (bus.mtlo) r_lo <= bus.Read_data_1;
                    if (bus.start) begin
                        r_is_div <= bus.op[1];
                        r_sign_q <= w_signed & (bus.Read_data_1[WIDTH-1] ^ bus.Read_data_2[WIDTH-1]);
                        r_sign_r <= w_signed & bus.Read_data_1[WIDTH-1];
                        r_raw_rs <= bus.Read_data_1;
                        r_cnt    <= '0;
                        // Divide: low half holds the dividend; multiply: low half holds the multiplier.
                        if (bus.op[1]) begin
                            r_opb  <= w_rt_abs;
                            r_prod <= {{WIDTH{1'b0}}, w_rs_abs};
                        end else begin
                            r_opb  <= w_rs_abs;
                            r_prod <= {{WIDTH{1'b0}}, w_rt_abs};
                        end
                    end
                end
                S_CALC: begin
                    r_cnt  <= r_cnt + 6'd1;
                    r_prod <= r_is_div ? w_div_next : w_mul_next;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    r_dbz  <= 1'b0;
                    if (r_is_div) begin
                        if (r_opb == '0) begin
                            r_hi  <= r_raw_rs;
                            r_lo  <= '1;
                            r_dbz <= 1'b1;
                        end else begin
                            r_lo <= r_sign_q ? -w_quo : w_quo;
                            r_hi <= r_sign_r ? -w_rem : w_rem;
                        end
                    end else begin
                        {r_hi, r_lo} <= r_sign_q ? -r_prod : r_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.HI          = r_hi;
    assign bus.LO          = r_lo;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Self-checking bench: vector table, corner sequences and random ops
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_muldiv_sequencer;
    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MULT_EN
        return op[1] ? 33 : 2;
`else
        return 33;
`endif
    endfunction

    // Plain-arithmetic reference: MIPS semantics via 64-bit integers.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        p   = '0;
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0) begin
                    p   = {a, 32'hFFFF_FFFF};
                    dbz = 1'b1;
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Called at #1 after a rising edge with the DUT idle.
    task automatic check_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit with_mt, input bit inject,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        logic [31:0] hold_hi, hold_lo;
        int          lat, bcnt;
        bit          held;
        bus.op          = op;
        bus.Read_data_1 = a;
        bus.Read_data_2 = b;
        bus.start       = 1'b1;
        bus.mthi        = with_mt;
        bus.mtlo        = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        hold_hi   = bus.HI;
        hold_lo   = bus.LO;
        check({tag, " done_clear"}, 64'(bus.done), 64'd0);
        if (with_mt) check({tag, " start_mthi"}, 64'(bus.HI), 64'(a));
        lat  = 0;
        bcnt = 0;
        held = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            if (bus.busy) bcnt++;
            if (bus.HI !== hold_hi || bus.LO !== hold_lo) held = 1'b0;
            if (inject && n == 3) begin
                bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
                bus.Read_data_1 = 32'hDEAD_BEEF; bus.Read_data_2 = 32'd0; bus.op = 2'b11;
            end
            if (n == 9) begin
                bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            end
            @(posedge clock); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        if (lat == 0) check({tag, " timeout"}, 64'd0, 64'd1);
        check({tag, " latency"},   64'(lat),  64'(exp_lat(op)));
        check({tag, " busy_cyc"},  64'(bcnt), 64'(exp_lat(op)));
        check({tag, " busy_done"}, 64'(bus.busy), 64'd0);
        check({tag, " hold"},      64'(held), 64'd1);
        check({tag, " HI"},        64'(bus.HI), 64'(ehi));
        check({tag, " LO"},        64'(bus.LO), 64'(elo));
        check({tag, " dbz"},       64'(bus.div_by_zero), 64'(edbz));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb, rhi, rlo;
        logic        rdbz;
        int          done_seen;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{2'b11, 32'h0000_0009, 32'h0000_0004, 32'h0000_0001, 32'h0000_0002, 1'b0};
        vecs[6] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[9] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};

        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.Read_data_1 = '0; bus.Read_data_2 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst HI",   64'(bus.HI), 64'd0);
        check("rst LO",   64'(bus.LO), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst dbz",  64'(bus.div_by_zero), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // MTHI / MTLO in IDLE commit on the next edge
        bus.mthi = 1'b1; bus.Read_data_1 = 32'h1234_5678;
        @(posedge clock); #1;
        bus.mthi = 1'b0;
        check("mthi HI", 64'(bus.HI), 64'h1234_5678);
        check("mthi LO", 64'(bus.LO), 64'd0);
        bus.mtlo = 1'b1; bus.Read_data_1 = 32'h9ABC_DEF0;
        @(posedge clock); #1;
        bus.mtlo = 1'b0;
        check("mtlo LO", 64'(bus.LO), 64'h9ABC_DEF0);
        check("mtlo HI", 64'(bus.HI), 64'h1234_5678);

        for (int i = 0; i < 10; i++)
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0,
                     vecs[i].hi, vecs[i].lo, vecs[i].dbz);

        // Writes and starts while busy are ignored
        check_op("inject_div", 2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0, 1'b1,
                 32'h0000_0002, 32'hFFFF_FFF2, 1'b0);
        check_op("inject_mul", 2'b01, 32'h0000_1234, 32'h0000_1000, 1'b0, 1'b1,
                 32'h0000_0000, 32'h0123_4000, 1'b0);
        // Start together with MTHI: HI takes rs first, result overwrites it
        check_op("start_mt", 2'b11, 32'h0000_0011, 32'h0000_0003, 1'b1, 1'b0,
                 32'h0000_0002, 32'h0000_0005, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            ref_model(rop, ra, rb, rhi, rlo, rdbz);
            check_op($sformatf("rnd%0d op%0d %h %h", i, rop, ra, rb), rop, ra, rb, 1'b0, 1'b0,
                     rhi, rlo, rdbz);
        end

        // Reset ten cycles into a DIV aborts it without a done
        bus.op = 2'b10; bus.Read_data_1 = 32'h7FFF_0000; bus.Read_data_2 = 32'h0000_0013;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("abort busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort HI",   64'(bus.HI), 64'd0);
        check("abort LO",   64'(bus.LO), 64'd0);
        check("abort busy", 64'(bus.busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (bus.done) done_seen++;
        end
        check("abort no_done", 64'(done_seen), 64'd0);
        check("abort idle",    64'(bus.busy), 64'd0);
        check_op("after_abort", 2'b11, 32'h0000_0009, 32'h0000_0004, 1'b0, 1'b0,
                 32'h0000_0001, 32'h0000_0002, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
